ssd_msg_scroller: RTL and testbench
===================================

Name: ssd_msg_scroller

Overview:
- Upstream feeder for the two-digit PmodSSD interface: supplies its `digit1`/`digit0` 5-bit character codes.
- Holds a short message loaded character-by-character over a valid/ready port. On command it scrolls the message across both digits, one position per step tick, with wrap-around.
- Character codes are the same 5-bit encoding the SSD segment decoder consumes.

Parameters:
- `DEPTH`, 16: maximum message length in characters (power of 2, ≥2).
- `CLK_HZ`, 100_000_000: input clock frequency.
- `STEP_HZ`, 4: scroll rate in positions per second.
- `SIMULATE`, 1: when 1, the step period is `SIM_STEP_CYCLES` (8) clocks instead of `CLK_HZ/STEP_HZ`.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `wr_valid`, input, 1: `wr_char` is valid this cycle.
- `wr_ready`, output, 1: block can accept a character.
- `wr_char`, input, 5: character code to append.
- `wr_last`, input, 1: qualifies `wr_valid`; this is the final character of the message.
- `start`, input, 1: single-cycle pulse; begin scrolling.
- `stop`, input, 1: single-cycle pulse; halt scrolling.
- `digit1`, output, 5: left-digit character code.
- `digit0`, output, 5: right-digit character code.
- `busy`, output, 1: high while in SCROLL.
- `msg_len`, output, $clog2(DEPTH)+1: number of stored characters.

Behaviour:
- Reset values: state EMPTY; `msg_len`=0; `ptr`=0; step counter=0; `digit1`=`digit0`=CHAR_BLANK (5'h1F); `busy`=0; `wr_ready`=1.
- Handshake: a write is accepted on any rising edge where `wr_valid` && `wr_ready`. Accepted characters are stored at index `msg_len`, then `msg_len` increments.
- **EMPTY**
  - `wr_ready`=1.
  - An accepted write goes to LOADING; if `wr_last` is set, to READY instead.
  - `start` is ignored.
- **LOADING**
  - `wr_ready`=1 while `msg_len` < DEPTH.
  - An accepted write with `wr_last` → READY.
  - An accepted write that makes `msg_len`==DEPTH → READY, even without `wr_last`. `wr_ready` drops in the same cycle.
  - `start` and `stop` are ignored.
  - Digits show CHAR_BLANK.
- **READY**
  - `wr_ready`=1.
  - An accepted write starts a new message: that character is stored at index 0, `msg_len` becomes 1, and the state goes to LOADING (or stays READY if `wr_last`).
  - `start` with no accepted write in the same cycle → SCROLL: `ptr`=0, step counter cleared.
  - If a write and `start` occur in the same cycle, the write wins and `start` is dropped.
  - Digits hold their last values. On first entry from LOADING/EMPTY, digits show buf[0] and buf[1 mod msg_len].
- **SCROLL**
  - `wr_ready`=0; `busy`=1.
  - Registered outputs: `digit1`=buf[ptr] and `digit0`=buf[(ptr+1) mod msg_len]. Outputs update one clock after `ptr` changes.
  - Each step tick: `ptr` ← (ptr+1 == msg_len) ? 0 : ptr+1.
  - If `msg_len`==1, both digits show buf[0].
  - `stop` → READY; digits freeze and `ptr` holds. If `stop` and `start` occur in the same cycle, `stop` wins.
  - `start` while already in SCROLL restarts: `ptr`=0, counter cleared.
- **Step timing:** the counter runs only in SCROLL. A tick fires when count == STEP_CYCLES-1, then the counter returns to 0. The first advance therefore occurs STEP_CYCLES clocks after entering SCROLL.
- **Reset mid-operation:** `reset` in any state returns all outputs to their reset values in the next cycle. Stored buffer contents are don't-care; `msg_len`=0 invalidates them.
- **Widths:** `ptr` is $clog2(DEPTH) bits. Modulo is done by compare-and-wrap, never by `%`.

Decomposition:
- Shared package CHAR_ROULETTE gains:
  - CHAR_BLANK = 5'h1F
  - the state enum `scroll_state_t` {EMPTY, LOADING, READY, SCROLL}
  - SIM_STEP_CYCLES = 8
- Sub-module `scroll_tick_gen` (parameters CLK_HZ, STEP_HZ, SIMULATE; ports `clk`, `reset`, `en`, `tick`). It is a free-running divider, cleared when `en`=0.
- Buffer is a register array inside the main module.

Test Plan:
- Reset, then idle 5 cycles → `digit1`=`digit0`=5'h1F, `wr_ready`=1, `busy`=0, `msg_len`=0.
- Load codes 1,2,3 (`wr_last` on 3), then pulse `start`, SIMULATE=1 → digits 1/2, after 8 clocks 2/3, after 16 clocks 3/1 (wrap), after 24 clocks 1/2.
- Load single code 7, then `start` → digits 7/7 indefinitely, `ptr` stays 0.
- Stream 20 writes without `wr_last` into DEPTH=16 → `wr_ready` falls after the 16th acceptance, `msg_len`=16, state READY, writes 17–20 not accepted.
- In SCROLL pulse `start` and `stop` together → state READY, digits frozen, `busy`=0. Later assert `wr_valid` and `start` together in READY → write accepted (`msg_len`=1), no scroll.
- Assert `reset` for one cycle mid-SCROLL → next cycle digits 5'h1F, `msg_len`=0, `busy`=0. A subsequent `start` is ignored.

Source files
------------

// File: rtl/ssd_msg_scroller_pkg.sv
// Shared definitions for the SSD message scroller: character codes, FSM states,
// and step-period selection.
package ssd_msg_scroller_pkg;

  localparam logic [4:0] CHAR_BLANK      = 5'h1F;
  localparam int         SIM_STEP_CYCLES = 8;

  typedef enum logic [1:0] {EMPTY, LOADING, READY, SCROLL} scroll_state_t;

  function automatic int step_cycles(input int clk_hz, input int step_hz, input bit sim);
    return sim ? SIM_STEP_CYCLES : clk_hz / step_hz;
  endfunction

endpackage

// File: rtl/ssd_msg_scroller_if.sv
// Character-load port, scroll control and digit outputs of the message scroller.
interface ssd_msg_scroller_if #(parameter int DEPTH = 16);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_char;
  logic          wr_last;
  logic          start;
  logic          stop;
  logic [4:0]    digit1;
  logic [4:0]    digit0;
  logic          busy;
  logic [LW-1:0] msg_len;

  modport master (
    output wr_valid, wr_char, wr_last, start, stop,
    input  wr_ready, digit1, digit0, busy, msg_len
  );

  modport slave (
    input  wr_valid, wr_char, wr_last, start, stop,
    output wr_ready, digit1, digit0, busy, msg_len
  );

endinterface

// File: rtl/ssd_msg_scroller_tick_gen.sv
// Free-running step divider; held at zero whenever en is low.
module scroll_tick_gen
  import ssd_msg_scroller_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int STEP_HZ  = 4,
  parameter int SIMULATE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int STEP_CYCLES = step_cycles(CLK_HZ, STEP_HZ, SIMULATE != 0);
  localparam int CW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || !en) r_cnt <= '0;
    else if (tick)    r_cnt <= '0;
    else              r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/ssd_msg_scroller.sv
// Loads a short message over a valid/ready port and scrolls it across the two
// PmodSSD digits, one position per step tick, wrapping at the message end.
module ssd_msg_scroller
  import ssd_msg_scroller_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int CLK_HZ   = 100_000_000,
  parameter int STEP_HZ  = 4,
  parameter int SIMULATE = 1
) (
  input  logic               clk,
  input  logic               reset,
  ssd_msg_scroller_if.slave  sif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  scroll_state_t r_state, w_state_nx;
  logic [4:0]    r_buf [DEPTH];
  logic [LW-1:0] r_len;
  logic [PW-1:0] r_ptr;
  logic [4:0]    r_d1, r_d0;
  logic          r_hold;

  logic          w_ready, w_acc, w_tick, w_tick_en;
  logic [PW-1:0] w_idx, w_ptr_nx;
  logic [LW-1:0] w_len_nx, w_inc;
  logic [4:0]    w_new_d1, w_new_d0;

  // Writes into READY start a new message at index 0.
  assign w_idx    = (r_state == READY) ? '0 : r_len[PW-1:0];
  assign w_len_nx = {1'b0, w_idx} + 1'b1;
  assign w_inc    = {1'b0, r_ptr} + 1'b1;
  assign w_ptr_nx = (w_inc == r_len) ? '0 : w_inc[PW-1:0];

  // Digits for a message that completes this cycle; the incoming char may be
  // one of the first two entries.
  assign w_new_d1 = (w_idx == '0)       ? sif.wr_char : r_buf[0];
  assign w_new_d0 = (w_idx <= PW'(1))   ? sif.wr_char : r_buf[1];

  // A start in SCROLL drops the enable for one edge, which clears the divider.
  assign w_tick_en = (r_state == SCROLL) && !sif.start;

  scroll_tick_gen #(.CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .SIMULATE(SIMULATE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (w_tick_en),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nx = r_state;
    w_ready    = 1'b0;
    w_acc      = 1'b0;
    case (r_state)
      EMPTY:   w_ready = 1'b1;
      LOADING: w_ready = (r_len < LW'(DEPTH));
      READY:   w_ready = !r_hold;
      default: w_ready = 1'b0;
    endcase
    w_acc = sif.wr_valid && w_ready;
    case (r_state)
      EMPTY, READY: begin
        if (w_acc)                                w_state_nx = sif.wr_last ? READY : LOADING;
        else if (r_state == READY && sif.start)   w_state_nx = SCROLL;
      end
      LOADING: if (w_acc && (sif.wr_last || w_len_nx == LW'(DEPTH))) w_state_nx = READY;
      SCROLL:  if (sif.stop) w_state_nx = READY;
      default: w_state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_buf[w_idx] <= sif.wr_char;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_len   <= '0;
      r_ptr   <= '0;
      r_d1    <= CHAR_BLANK;
      r_d0    <= CHAR_BLANK;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_acc) begin
        r_len <= w_len_nx;
        r_d1  <= (w_state_nx == LOADING) ? CHAR_BLANK : w_new_d1;
        r_d0  <= (w_state_nx == LOADING) ? CHAR_BLANK : w_new_d0;
      end
      // A message that fills without wr_last keeps the port closed until the
      // writer lets go of wr_valid, so surplus chars don't open a new message.
      if (w_acc && !sif.wr_last && w_len_nx == LW'(DEPTH)) r_hold <= 1'b1;
      else if (!sif.wr_valid)                              r_hold <= 1'b0;
      if (r_state == SCROLL && !sif.stop) begin
        r_d1 <= r_buf[r_ptr];
        r_d0 <= r_buf[w_ptr_nx];
        if (sif.start)   r_ptr <= '0;
        else if (w_tick) r_ptr <= w_ptr_nx;
      end else if (w_state_nx == SCROLL) begin
        r_ptr <= '0;
      end
    end
  end

  assign sif.wr_ready = w_ready;
  assign sif.busy     = (r_state == SCROLL);
  assign sif.digit1   = r_d1;
  assign sif.digit0   = r_d0;
  assign sif.msg_len  = r_len;

endmodule

// File: tb/tb_ssd_msg_scroller.sv
// Directed + randomized bench for ssd_msg_scroller against a queue-based
// message model with step-time arithmetic.
module tb_ssd_msg_scroller;
  import ssd_msg_scroller_pkg::*;

  localparam int DEPTH = 16;
  localparam int STEP  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ssd_msg_scroller_if #(.DEPTH(DEPTH)) bus ();

  ssd_msg_scroller #(.DEPTH(DEPTH), .CLK_HZ(100_000_000), .STEP_HZ(4), .SIMULATE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (bus)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  int         msg[$];
  logic [4:0] e1, e0;
  int         p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    msg.delete();
  endtask

  task automatic write1(input logic [4:0] c, input logic last);
    bus.wr_valid = 1'b1;
    bus.wr_char  = c;
    bus.wr_last  = last;
    msg.push_back(int'(c));
    step();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic set_exp(input int pp);
    e1 = 5'(msg[pp]);
    e0 = 5'(msg[(pp + 1) % msg.size()]);
  endtask

  // Caller raises start before calling. After edge k the pointer equals
  // floor(k/STEP) mod len, and the digits trail the pointer by one edge.
  task automatic scroll_run(input string tag, input int ncyc, input int p_prev, output int p_last);
    for (int k = 0; k < ncyc; k++) begin
      step();
      bus.start = 1'b0;
      set_exp((k == 0) ? p_prev : ((k - 1) / STEP) % msg.size());
      chk({tag, "_d1"}, bus.digit1, e1);
      chk({tag, "_d0"}, bus.digit0, e0);
      chk({tag, "_busy"}, bus.busy, 1);
    end
    p_last = ((ncyc - 1) / STEP) % msg.size();
  endtask

  initial begin
    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_char  = '0;
    bus.wr_last  = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    step();
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("rst_d1", bus.digit1, CHAR_BLANK);
    chk("rst_d0", bus.digit0, CHAR_BLANK);
    chk("rst_rdy", bus.wr_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_len", bus.msg_len, 0);

    // Three-char message with wrap.
    write1(5'd1, 1'b0);
    write1(5'd2, 1'b0);
    write1(5'd3, 1'b1);
    chk("abc_len", bus.msg_len, 3);
    chk("abc_d1", bus.digit1, 1);
    chk("abc_d0", bus.digit0, 2);
    chk("abc_busy", bus.busy, 0);
    bus.start = 1'b1;
    scroll_run("abc", 40, 0, p);
    bus.start = 1'b1;
    scroll_run("restart", 21, p, p);

    // stop beats start; digits freeze.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("stop_busy", bus.busy, 0);
    chk("stop_d1", bus.digit1, e1);
    chk("stop_d0", bus.digit0, e0);
    chk("stop_rdy", bus.wr_ready, 1);
    repeat (10) step();
    chk("frz_d1", bus.digit1, e1);
    chk("frz_d0", bus.digit0, e0);

    // write beats start in READY.
    bus.wr_valid = 1'b1;
    bus.wr_char  = 5'd9;
    bus.start    = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.start    = 1'b0;
    chk("ws_len", bus.msg_len, 1);
    chk("ws_busy", bus.busy, 0);
    chk("ws_d1", bus.digit1, CHAR_BLANK);
    chk("ws_rdy", bus.wr_ready, 1);
    step();
    chk("ws_busy2", bus.busy, 0);

    // Single-character message.
    do_reset();
    write1(5'd7, 1'b1);
    chk("one_len", bus.msg_len, 1);
    bus.start = 1'b1;
    scroll_run("one", 30, 0, p);

    // Overfill without wr_last.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [4:0] c;
      c = 5'($urandom_range(0, 31));
      bus.wr_valid = 1'b1;
      bus.wr_char  = c;
      chk("fill_rdy", bus.wr_ready, (i < DEPTH) ? 1 : 0);
      if (i < DEPTH) msg.push_back(int'(c));
      step();
    end
    chk("fill_len", bus.msg_len, DEPTH);
    chk("fill_d1", bus.digit1, msg[0]);
    chk("fill_d0", bus.digit0, msg[1]);
    bus.wr_valid = 1'b0;
    step();
    chk("fill_rdy_rel", bus.wr_ready, 1);
    chk("fill_len2", bus.msg_len, DEPTH);
    chk("fill_busy", bus.busy, 0);
    bus.start = 1'b1;
    scroll_run("fill", DEPTH * STEP + 4, 0, p);

    // Reset mid-scroll, then start is ignored in EMPTY.
    reset = 1'b1;
    step();
    reset = 1'b0;
    msg.delete();
    chk("mrst_d1", bus.digit1, CHAR_BLANK);
    chk("mrst_d0", bus.digit0, CHAR_BLANK);
    chk("mrst_len", bus.msg_len, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_rdy", bus.wr_ready, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("mrst_start_busy", bus.busy, 0);
    chk("mrst_start_d1", bus.digit1, CHAR_BLANK);

    // Randomized messages, scroll lengths and stops.
    for (int r = 0; r < 8; r++) begin
      int n;
      int nc;
      do_reset();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) write1(5'($urandom_range(0, 31)), (i == n - 1) ? 1'b1 : 1'b0);
      chk("rnd_len", bus.msg_len, n);
      chk("rnd_ld_d1", bus.digit1, msg[0]);
      chk("rnd_ld_d0", bus.digit0, msg[1 % n]);
      nc = $urandom_range(10, 80);
      bus.start = 1'b1;
      scroll_run("rnd", nc, 0, p);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("rnd_stop_busy", bus.busy, 0);
      chk("rnd_stop_d1", bus.digit1, e1);
      chk("rnd_stop_d0", bus.digit0, e0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
